zyx_capture_fifo: RTL and testbench

- Downstream consumer of the registered z/y/x flags produced by the M1/M2/M3 register chain.
- Packs the three flags into a 3-bit sample each clock and detects any change against the previously seen sample.
- Each changed sample is queued in a small FIFO, which is drained through a valid/ready handshake to a logger or checker.
- Overflow is reported, not blocking; the flag producers cannot be stalled.

---
 rtl/zyx_pkg.sv | 23 ++
 rtl/zyx_change_detect.sv | 36 +++
 rtl/zyx_capture_fifo.sv | 111 +++++++++++
 tb/tb_zyx_capture_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/zyx_pkg.sv
// Shared types and helpers for the z/y/x flag capture path.
package zyx_pkg;

  // One captured flag sample. The packed layout is {z,y,x}, so bit 2 is z.
  typedef struct packed {
    logic z;
    logic y;
    logic x;
  } zyx_t;

  // Value of the "previously seen" sample after reset.
  localparam logic [2:0] ZYX_RESET = 3'b000;

  // Packs the three separate flags into one sample.
  function automatic zyx_t zyx_pack(input logic z, input logic y, input logic x);
    zyx_t r;
    r.z = z;
    r.y = y;
    r.x = x;
    return r;
  endfunction

endpackage

// File: rtl/zyx_change_detect.sv
// Packs the incoming flags and flags any difference from the last sample seen.
module zyx_change_detect
  import zyx_pkg::*;
(
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_srst,
  input  logic i_z,
  input  logic i_y,
  input  logic i_x,
  output zyx_t o_sample,
  output logic o_push
);

  zyx_t r_prev;
  zyx_t w_sample;

  // Current sample and change flag, both combinational.
  always_comb begin
    w_sample = zyx_pack(i_z, i_y, i_x);
    o_sample = w_sample;
    o_push   = (w_sample != r_prev);
  end

  // prev tracks every sample, even ones the FIFO ends up dropping.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_prev <= ZYX_RESET;
    end else if (i_srst) begin
      r_prev <= ZYX_RESET;
    end else begin
      r_prev <= w_sample;
    end
  end

endmodule

// File: rtl/zyx_capture_fifo.sv
// Captures changes of the z/y/x flags into a small FIFO drained by a consumer.
// Handshake: o_data is presented while o_valid=1. An entry is removed on a
// posedge where o_valid && i_ready. o_valid never waits on i_ready, and o_data
// holds steady until the entry is taken. Producers are never stalled. A change
// that arrives while the FIFO is full and nothing pops is dropped and counted.
module zyx_capture_fifo
  import zyx_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                         i_clk,
  input  logic                         i_arst,
  input  logic                         i_srst,
  input  logic                         i_z,
  input  logic                         i_y,
  input  logic                         i_x,
  output logic [2:0]                   o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_overflow,
  output logic [DROP_W-1:0]            o_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);

  zyx_t              w_sample;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_drop;
  logic [PW-1:0]     w_level;

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [2:0]        r_mem [DEPTH];
  logic              r_overflow;
  logic [DROP_W-1:0] r_drops;

  zyx_change_detect u_detect (
    .i_clk    (i_clk),
    .i_arst   (i_arst),
    .i_srst   (i_srst),
    .i_z      (i_z),
    .i_y      (i_y),
    .i_x      (i_x),
    .o_sample (w_sample),
    .o_push   (w_push)
  );

  // Pointer status and accept/drop decisions. A full FIFO still accepts a
  // push when the head leaves in the same cycle.
  always_comb begin
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_pop   = !w_empty && i_ready;
    w_wr    = w_push && (!w_full || w_pop);
    w_drop  = w_push && w_full && !w_pop;
    w_level = r_wptr - r_rptr;
  end

  // Outputs read straight from registered state, so no fall-through.
  always_comb begin
    o_data     = r_mem[r_rptr[AW-1:0]];
    o_valid    = !w_empty;
    o_level    = LW'(w_level);
    o_overflow = r_overflow;
    o_drops    = r_drops;
  end

  // Storage carries no reset; its contents only matter while o_valid=1.
  always_ff @(posedge i_clk) begin
    if (w_wr && !i_srst) begin
      r_mem[r_wptr[AW-1:0]] <= w_sample;
    end
  end

  // Pointers, sticky overflow and saturating drop count.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else if (i_srst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != '1) begin
          r_drops <= r_drops + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_zyx_capture_fifo.sv
// Bench for zyx_capture_fifo: directed scenarios plus a randomized phase,
// all checked against a queue-based reference model.
module tb_zyx_capture_fifo;

  localparam int DEPTH    = 4;
  localparam int DROP_W   = 2;
  localparam int LW       = $clog2(DEPTH + 1);
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              i_clk;
  logic              i_arst;
  logic              i_srst;
  logic              i_z;
  logic              i_y;
  logic              i_x;
  logic [2:0]        o_data;
  logic              o_valid;
  logic              i_ready;
  logic [LW-1:0]     o_level;
  logic              o_overflow;
  logic [DROP_W-1:0] o_drops;

  // Reference model state.
  logic [2:0] exp_q[$];
  logic [2:0] m_prev;
  logic       m_ovf;
  int         m_drops;

  int n_checks;
  int n_fail;

  zyx_capture_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_srst     (i_srst),
    .i_z        (i_z),
    .i_y        (i_y),
    .i_x        (i_x),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .o_drops    (o_drops)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_prev  = 3'b000;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // One clock of the reference: the consumer takes the head first, then a
  // changed sample joins the tail if there is room, otherwise it is lost.
  task automatic model_step(input logic [2:0] s, input logic rdy, input logic srst);
    if (srst) begin
      model_clear();
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (s != m_prev) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(s);
        end else begin
          m_ovf   = 1'b1;
          m_drops = (m_drops == DROP_MAX) ? DROP_MAX : m_drops + 1;
        end
      end
      m_prev = s;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(o_valid), 32'(exp_q.size() != 0));
    check({tag, ".level"}, 32'(o_level), 32'(exp_q.size()));
    if (exp_q.size() != 0) check({tag, ".data"}, 32'(o_data), 32'(exp_q[0]));
    check({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
    check({tag, ".drops"}, 32'(o_drops), 32'(m_drops));
  endtask

  // Driver: apply inputs on the falling edge, check #1 after the rising edge.
  task automatic cycle(input string tag, input logic [2:0] s, input logic rdy, input logic srst);
    @(negedge i_clk);
    {i_z, i_y, i_x} = s;
    i_ready = rdy;
    i_srst  = srst;
    model_step(s, rdy, srst);
    @(posedge i_clk);
    #1;
    check_outputs(tag);
  endtask

  logic [2:0] ovf_pat [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    i_arst  = 1'b1;
    i_srst  = 1'b0;
    i_ready = 1'b0;
    {i_z, i_y, i_x} = 3'b000;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_arst = 1'b0;
    #1;
    check_outputs("reset");

    // Steady inputs produce no pushes.
    for (int i = 0; i < 10; i++) cycle("steady", 3'b000, 1'($urandom_range(0, 1)), 1'b0);

    // Ordered capture then drain.
    cycle("cap0", 3'b001, 1'b0, 1'b0);
    cycle("cap1", 3'b011, 1'b0, 1'b0);
    cycle("cap2", 3'b111, 1'b0, 1'b0);
    check("cap.level3", 32'(o_level), 32'd3);
    check("cap.head", 32'(o_data), 32'h1);
    for (int i = 0; i < 4; i++) cycle("drain", 3'b111, 1'b1, 1'b0);

    // Overflow: six changes into a four-entry FIFO.
    ovf_pat = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    for (int i = 0; i < 6; i++) cycle("ovf", ovf_pat[i], 1'b0, 1'b0);
    check("ovf.level4", 32'(o_level), 32'd4);
    check("ovf.flag", 32'(o_overflow), 32'd1);
    check("ovf.drops2", 32'(o_drops), 32'd2);

    // Full with a change and a pop in the same cycle: accepted, no drop.
    cycle("fullpp", 3'b111, 1'b1, 1'b0);
    check("fullpp.level4", 32'(o_level), 32'd4);
    check("fullpp.drops2", 32'(o_drops), 32'd2);
    for (int i = 0; i < 5; i++) cycle("drain2", 3'b111, 1'b1, 1'b0);

    // Synchronous clear, also colliding with a change and a ready consumer.
    cycle("srst", 3'b010, 1'b1, 1'b1);
    check("srst.ovf0", 32'(o_overflow), 32'd0);
    check("srst.drops0", 32'(o_drops), 32'd0);

    // Saturation: four fills plus five drops.
    for (int i = 0; i < 9; i++) cycle("sat", 3'(i + 1), 1'b0, 1'b0);
    check("sat.drops3", 32'(o_drops), 32'(DROP_MAX));
    cycle("pop1", 3'b001, 1'b1, 1'b0);

    // Asynchronous reset between edges with three entries stored.
    @(negedge i_clk);
    i_ready = 1'b0;
    #2;
    i_arst = 1'b1;
    #1;
    model_clear();
    check("arst.valid0", 32'(o_valid), 32'd0);
    check("arst.level0", 32'(o_level), 32'd0);
    check("arst.ovf0", 32'(o_overflow), 32'd0);
    @(negedge i_clk);
    {i_z, i_y, i_x} = 3'b000;
    i_arst = 1'b0;
    cycle("post_arst", 3'b000, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 3'($urandom_range(0, 7)) & (($urandom_range(0, 3) == 0) ? 3'b000 : 3'b111),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
